// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift controller and its single-step shifter.
//   - FSM state encodings (IDLE, SHIFT, DONE)
//   - shift direction encodings
//   - default operand and count widths
package shift_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic DIR_RIGHT = 1'b0;  // halve, MSB fill 0
  localparam logic DIR_LEFT  = 1'b1;  // double, LSB fill 0

endpackage

// File: rtl/shift_step.sv
// Combinational single-step logical shifter.
// Ports:
//   data        - operand
//   dir         - DIR_RIGHT (halve) or DIR_LEFT (double)
//   next_data   - operand shifted by one bit, vacated bit filled with 0
//   shifted_out - the bit that fell off the end
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  output logic [WIDTH-1:0] next_data,
  output logic             shifted_out
);

  always_comb begin
    if (dir == DIR_LEFT) begin
      next_data   = {data[WIDTH-2:0], 1'b0};
      shifted_out = data[WIDTH-1];
    end else begin
      next_data   = {1'b0, data[WIDTH-1:1]};
      shifted_out = data[0];
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// Iterative shift controller: accepts (operand, direction, count) over a valid/ready
// handshake, applies one 1-bit step per clock, then offers result and last shifted-out
// bit over a valid/ready output handshake.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - command handshake; in_data, in_dir, in_cnt are the command
//   out_valid/out_ready   - result handshake; out_data, out_carry are the result
//   busy                  - command in flight (SHIFT or DONE)
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] step_data;
  logic             step_out;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data       (data_q),
    .dir        (dir_q),
    .next_data  (step_data),
    .shifted_out(step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          dir_d   = in_dir;
          rem_d   = in_cnt;
          carry_d = 1'b0;
          state_d = (in_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d  = step_data;
        carry_d = step_out;
        rem_d   = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE only; a new command is never taken in the same cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= DIR_RIGHT;
      rem_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_carry = carry_q;

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
- Iterative shift controller that sits directly upstream of the team's single-step halve/double shifter.
- Accepts a shift command (operand, direction, count) over a valid/ready handshake.
- Applies one 1-bit halve (right) or double (left) step per clock for `count` clocks.
- Presents the final result, plus the last bit shifted out, over a valid/ready output handshake to the consumer.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 4, width of the shift-count field (max count 2^CNT_W-1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  controller can accept a command.
- in_data  input  WIDTH  operand.
- in_dir  input  1  0 = right (halve, MSB fill 0), 1 = left (double, LSB fill 0).
- in_cnt  input  CNT_W  number of 1-bit steps.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted out (0 if in_cnt = 0).
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: synchronous, active-high; one clock edge with rst = 1 is sufficient.
  - Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_carry = 0, busy = 0, internal count = 0.
  - Reset mid-operation aborts the command with no output produced.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). busy = (state != IDLE).
- IDLE:
  - On an edge with in_valid & in_ready: capture in_data into the data register, in_dir into the dir register, in_cnt into the remaining-count register, and clear carry.
  - Next state: DONE if in_cnt == 0, otherwise SHIFT.
- SHIFT, each edge:
  - Right: data <= data >> 1, carry <= data[0].
  - Left: data <= data << 1 (truncated to WIDTH), carry <= data[WIDTH-1].
  - remaining <= remaining - 1.
  - If remaining == 1 before the decrement, next state = DONE.
- DONE:
  - out_data and out_carry hold stable while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE; out_data and out_carry hold their last values.
- Latency: out_valid rises (in_cnt + 1) edges after the accepting edge counts inclusively. cnt = 0 gives out_valid after the accept edge; cnt = 3 gives out_valid after accept + 3 shift edges.
- Throughput: one command per (in_cnt + 2) cycles minimum. No accept in DONE, even if out_ready is high the same cycle.
- Boundary conditions:
  - cnt ≥ WIDTH: data becomes 0 after WIDTH steps. Shifting continues for the full count. Carry is 0 for steps beyond WIDTH.
  - in_valid while in_ready = 0: ignored, no side effects. Inputs are not sampled outside IDLE accept edges.
  - out_ready high outside DONE: ignored.
  - rst and in_valid together: rst wins, no command accepted.
- Arithmetic: logical shifts only, no sign extension. Halve truncates toward zero; double discards overflow, which is reported via carry.

Decomposition:
- shift_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1.
  - Default WIDTH/CNT_W localparams.
- Sub-module shift_step: combinational single-step shifter (data, dir → next_data, shifted_out_bit). Instanced once in shift_ctrl and reusable by neighbouring stages.
- FSM, counter and handshake logic stay in shift_ctrl.

Test Plan:
- Right shift: in_data = 0x04, dir = 0, cnt = 1, out_ready = 1. Expect out_data = 0x02 and out_carry = 0, with out_valid 2 edges after accept; in_ready returns high the cycle after the output handshake.
- Left shift with carry: in_data = 0x81, dir = 1, cnt = 1. Expect out_data = 0x02, out_carry = 1. Then 0xB5, dir = 0, cnt = 3. Expect out_data = 0x16, out_carry = 1, out_valid 4 edges after accept.
- Zero and oversized counts: 0x5A, cnt = 0 → out_data = 0x5A, out_carry = 0, out_valid after 1 edge. 0xFF, dir = 1, cnt = 10 → out_data = 0x00, out_carry = 0, out_valid after 11 edges.
- Backpressure: complete a command with out_ready = 0 for 5 cycles. Expect out_valid, out_data and out_carry stable and in_ready = 0 throughout. A new in_valid pulse during this window is ignored; the next accepted command is the one presented after return to IDLE.
- Reset mid-operation: accept 0x80, dir = 0, cnt = 7, then assert rst for 1 cycle after 3 shift edges. Expect all outputs at reset values the next cycle and no out_valid. A subsequent command of 0x10, dir = 1, cnt = 2 yields 0x40.
- Back-to-back commands: send 0x01/left/4 then 0x80/right/4 with out_ready = 1 and in_valid held. Expect results 0x10 then 0x08, each with carry 0, separated by 6 cycles accept-to-accept.
